// File: rtl/frame_scheduler.sv
// Frame scheduler: arms on enable, launches one frame per frame_tick, counts
// 4-pixel beats between the pattern generator and the sink, and tracks overruns.
module frame_scheduler #(
  parameter int DEFAULT_WIDTH  = 640,
  parameter int DEFAULT_HEIGHT = 480,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_tick,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [15:0]            cfg_width,
  input  logic [15:0]            cfg_height,
  output logic [15:0]            video_width,
  output logic [15:0]            video_height,
  output logic                   start_frame,
  input  logic                   gen_valid,
  output logic                   gen_ready,
  output logic                   sink_valid,
  input  logic                   sink_ready,
  output logic                   frame_done,
  output logic                   cfg_error,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] overrun_count,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACTIVE
  } state_t;

  localparam logic [15:0] DefWidth  = 16'(DEFAULT_WIDTH);
  localparam logic [15:0] DefHeight = 16'(DEFAULT_HEIGHT);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [15:0]            r_pendWidth;
  logic [15:0]            r_pendHeight;
  logic [15:0]            r_videoWidth;
  logic [15:0]            r_videoHeight;
  logic [15:0]            r_x;
  logic [15:0]            r_y;
  logic                   r_startFrame;
  logic                   r_frameDone;
  logic                   r_cfgError;
  logic [COUNT_WIDTH-1:0] r_frameCount;
  logic [COUNT_WIDTH-1:0] r_overrunCount;

  logic                   w_latch;
  logic                   w_beat;
  logic                   w_xLast;
  logic                   w_yLast;
  logic                   w_lastBeat;
  logic                   w_cfgOk;
  logic                   w_sinkValid;
  logic                   w_genReady;

  // Beats are 4 pixels wide, so the row length in beats is video_width[15:2].
  assign w_xLast    = (r_x == ({2'b00, r_videoWidth[15:2]} - 16'd1));
  assign w_yLast    = (r_y == (r_videoHeight - 16'd1));
  assign w_beat     = (r_state == ACTIVE) && gen_valid && sink_ready;
  assign w_lastBeat = w_beat && w_xLast && w_yLast;
  assign w_cfgOk    = (cfg_width != 16'd0) && (cfg_width[1:0] == 2'b00) &&
                      (cfg_height != 16'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_latch     = 1'b0;
    w_sinkValid = 1'b0;
    w_genReady  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_nextState = ARM;
        end
      end
      ARM: begin
        if (!enable) begin
          w_nextState = IDLE;
        end else if (frame_tick) begin
          w_nextState = ACTIVE;
          w_latch     = 1'b1;
        end
      end
      ACTIVE: begin
        w_sinkValid = gen_valid;
        w_genReady  = sink_ready;
        // Dropping enable never aborts a frame; it only decides where we land.
        if (w_lastBeat) begin
          w_nextState = enable ? ARM : IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Pending geometry only; the live geometry is copied from here at launch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pendWidth  <= DefWidth;
      r_pendHeight <= DefHeight;
      r_cfgError   <= 1'b0;
    end else begin
      r_cfgError <= 1'b0;
      if (cfg_valid) begin
        if (w_cfgOk) begin
          r_pendWidth  <= cfg_width;
          r_pendHeight <= cfg_height;
        end else begin
          r_cfgError <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_videoWidth  <= DefWidth;
      r_videoHeight <= DefHeight;
      r_x           <= 16'd0;
      r_y           <= 16'd0;
      r_startFrame  <= 1'b0;
      r_frameDone   <= 1'b0;
    end else begin
      r_startFrame <= w_latch;
      r_frameDone  <= w_lastBeat;
      if (w_latch) begin
        r_videoWidth  <= r_pendWidth;
        r_videoHeight <= r_pendHeight;
        r_x           <= 16'd0;
        r_y           <= 16'd0;
      end else if (w_beat) begin
        if (w_xLast) begin
          r_x <= 16'd0;
          r_y <= w_yLast ? 16'd0 : (r_y + 16'd1);
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
    end
  end

  // A tick while a frame is in flight (even on its last beat) is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frameCount   <= '0;
      r_overrunCount <= '0;
    end else begin
      if (w_lastBeat) begin
        r_frameCount <= r_frameCount + COUNT_WIDTH'(1);
      end
      if ((r_state == ACTIVE) && frame_tick && (r_overrunCount != '1)) begin
        r_overrunCount <= r_overrunCount + COUNT_WIDTH'(1);
      end
    end
  end

  assign cfg_ready     = 1'b1;
  assign video_width   = r_videoWidth;
  assign video_height  = r_videoHeight;
  assign start_frame   = r_startFrame;
  assign frame_done    = r_frameDone;
  assign cfg_error     = r_cfgError;
  assign frame_count   = r_frameCount;
  assign overrun_count = r_overrunCount;
  assign sink_valid    = w_sinkValid;
  assign gen_ready     = w_genReady;
  assign busy          = (r_state != IDLE);

endmodule
